// File: rtl/awgn_pkg.sv
// awgn_pkg: shared Q7 sample types and saturation bounds for the AWGN channel
package awgn_pkg;
    localparam int Q_FRAC = 7;
    localparam int WIDTH_DEF = 16;
    localparam logic signed [WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic signed [WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};
    typedef logic signed [WIDTH_DEF-1:0] sample_t;
    typedef struct packed {
        sample_t i;
        sample_t q;
    } iq_t;
endpackage

// File: rtl/awgn_sat_add.sv
// awgn_sat_add: one-bit-wider signed add clamped back to WIDTH, with clamp flag
module awgn_sat_add
    import awgn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    sat
);
    logic signed [WIDTH:0] s;
    assign s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Top two bits disagree exactly when the result left the WIDTH range
    assign sat = s[WIDTH] != s[WIDTH-1];
    assign sum = sat ? {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}} : s[WIDTH-1:0];
endmodule

// File: rtl/awgn_channel.sv
// awgn_channel: 2-stage I/Q + scaled noise saturating adder; sat_cnt built only with AWGN_SAT_CNT_EN
module awgn_channel
    import awgn_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHIFT_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_i,
    input  logic signed [WIDTH-1:0] s_q,
    input  logic signed [WIDTH-1:0] noise_i,
    input  logic signed [WIDTH-1:0] noise_q,
    input  logic                    noise_en,
    input  logic [SHIFT_W-1:0]      noise_shift,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_i,
    output logic signed [WIDTH-1:0] m_q,
    output logic [1:0]              m_sat,
    output logic [CNT_W-1:0]        sat_cnt,
    input  logic                    sat_clr
);
    logic v1, v2, adv1, adv2, sat_i, sat_q;
    logic signed [WIDTH-1:0] s1_i, s1_q, n1_i, n1_q, sh_i, sh_q, sum_i, sum_q;
    assign adv2    = !v2 || m_ready;
    assign adv1    = !v1 || adv2;
    assign s_ready = adv1;
    assign m_valid = v2;
    // Shift kept separate from the enable mux so the shift stays arithmetic
    assign sh_i = noise_i >>> noise_shift;
    assign sh_q = noise_q >>> noise_shift;
    awgn_sat_add #(.WIDTH(WIDTH)) u_add_i (.a(s1_i), .b(n1_i), .sum(sum_i), .sat(sat_i));
    awgn_sat_add #(.WIDTH(WIDTH)) u_add_q (.a(s1_q), .b(n1_q), .sum(sum_q), .sat(sat_q));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            s1_i  <= '0;
            s1_q  <= '0;
            n1_i  <= '0;
            n1_q  <= '0;
            m_i   <= '0;
            m_q   <= '0;
            m_sat <= '0;
        end else begin
            if (adv1) begin
                v1 <= s_valid;
                if (s_valid) begin
                    s1_i <= s_i;
                    s1_q <= s_q;
                    n1_i <= noise_en ? sh_i : '0;
                    n1_q <= noise_en ? sh_q : '0;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    m_i   <= sum_i;
                    m_q   <= sum_q;
                    m_sat <= {sat_q, sat_i};
                end
            end
        end
    end
`ifdef AWGN_SAT_CNT_EN
    logic bump;
    assign bump = v2 && m_ready && |m_sat && sat_cnt != {CNT_W{1'b1}};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt <= '0;
        else if (sat_clr) sat_cnt <= '0;
        else if (bump) sat_cnt <= sat_cnt + 1'b1;
    end
`else
    assign sat_cnt = {CNT_W{sat_clr & 1'b0}};
`endif
endmodule

// File: tb/tb_awgn_channel.sv
// tb_awgn_channel: directed checks of the AWGN channel pipeline, saturation and counter
module tb_awgn_channel;
    logic clk = 1'b0, rst = 1'b1;
    logic s_valid = 1'b0, s_ready, noise_en = 1'b0, m_valid, m_ready = 1'b1, sat_clr = 1'b0;
    logic [15:0] s_i = '0, s_q = '0, noise_i = '0, noise_q = '0, m_i, m_q;
    logic [2:0] noise_shift = '0;
    logic [1:0] m_sat;
    logic [3:0] sat_cnt;
    int checks = 0, failures = 0;
`ifdef AWGN_SAT_CNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    awgn_channel #(.WIDTH(16), .SHIFT_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
        .noise_i(noise_i), .noise_q(noise_q), .noise_en(noise_en), .noise_shift(noise_shift),
        .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q), .m_sat(m_sat),
        .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [15:0] si, sq, ni, nq, input logic en, input logic [2:0] sh,
                            input logic [15:0] ei, eq, input logic [1:0] es);
        s_i = si; s_q = sq; noise_i = ni; noise_q = nq; noise_en = en; noise_shift = sh;
        m_ready = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        noise_i = 16'h5555; noise_en = ~en;
        chk("lat1_valid", 32'(m_valid), 32'd0);
        tick();
        chk("out_valid", 32'(m_valid), 32'd1);
        chk("out_i", 32'(m_i), 32'(ei));
        chk("out_q", 32'(m_q), 32'(eq));
        chk("out_sat", 32'(m_sat), 32'(es));
        tick();
    endtask

    initial begin
        int sent, recv;
        logic in_x;
        #12;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_i", 32'(m_i), 32'd0);
        chk("rst_sat", 32'(m_sat), 32'd0);
        chk("rst_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(s_ready), 32'd1);

        send_one(16'h0100, 16'hFF00, 16'h0400, 16'h0400, 1'b0, 3'd0, 16'h0100, 16'hFF00, 2'b00);
        send_one(16'h0100, 16'h0000, 16'h0080, 16'h0000, 1'b1, 3'd0, 16'h0180, 16'h0000, 2'b00);
        send_one(16'h0100, 16'h0000, 16'hFF80, 16'h0000, 1'b1, 3'd2, 16'h00E0, 16'h0000, 2'b00);
        send_one(16'h0000, 16'h0010, 16'hFFFF, 16'h7FFF, 1'b1, 3'd7, 16'hFFFF, 16'h010F, 2'b00);
        send_one(16'h7F00, 16'h8100, 16'h0200, 16'hFE00, 1'b1, 3'd0, 16'h7FFF, 16'h8000, 2'b11);
        chk("cnt_one", 32'(sat_cnt), CE ? 32'd1 : 32'd0);

        noise_en = 1'b0;
        sent = 0; recv = 0;
        for (int c = 0; c < 40 && recv < 10; c++) begin
            s_valid = sent < 10;
            s_i = 16'h0100 + 16'(sent);
            s_q = 16'h0200 - 16'(sent);
            m_ready = !(c >= 4 && c < 9);
            #1;
            chk("stall_ready", 32'(s_ready), 32'(m_ready || (sent - recv < 2)));
            in_x = s_valid && s_ready;
            if (m_valid) begin
                chk("strm_i", 32'(m_i), 32'(16'h0100 + 16'(recv)));
                chk("strm_q", 32'(m_q), 32'(16'h0200 - 16'(recv)));
                if (m_ready) recv++;
            end
            @(posedge clk);
            if (in_x) sent++;
            #1;
        end
        chk("strm_count", 32'(recv), 32'd10);
        s_valid = 1'b0; m_ready = 1'b1;
        tick();

        s_i = 16'h7F00; s_q = 16'h0000; noise_i = 16'h0200; noise_q = 16'h0000;
        noise_en = 1'b1; noise_shift = 3'd0; m_ready = 1'b0; s_valid = 1'b1;
        tick();
        tick();
        chk("inflt_valid", 32'(m_valid), 32'd1);
        chk("inflt_sat", 32'(m_sat), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(m_valid), 32'd0);
        chk("arst_i", 32'(m_i), 32'd0);
        chk("arst_sat", 32'(m_sat), 32'd0);
        chk("arst_cnt", 32'(sat_cnt), 32'd0);
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_stale", 32'(m_valid), 32'd0);
        end

        s_valid = 1'b1;
        repeat (16) tick();
        s_valid = 1'b0;
        repeat (2) tick();
        chk("cnt_sat", 32'(sat_cnt), CE ? 32'd15 : 32'd0);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("clr_valid", 32'(m_valid), 32'd1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_prio", 32'(sat_cnt), 32'd0);
        send_one(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 1'b1, 3'd0, 16'h7FFF, 16'h0000, 2'b01);
        chk("cnt_after_clr", 32'(sat_cnt), CE ? 32'd1 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
